tri_mem_arbiter: RTL and testbench
==================================

TRI_MEM_ARBITER -- requirements
Module: tri_mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of streamer requesters sharing one triangle memory read port (2..8).
REQ-002 Parameter M_BITS, default 12: triangle memory address width.
REQ-003 Parameter D_BITS, default 32: width of one signed memory word.
REQ-004 Parameter MAX_BURST, default 4: maximum consecutive grants to one requester; used only with ARB_LOCK_EN.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req  input  NUM_REQ  per-requester read request; bit i from streamer i.
REQ-008 req_addr  input  NUM_REQ*M_BITS  packed addresses; slice [i*M_BITS +: M_BITS] belongs to requester i.
REQ-009 gnt  output  NUM_REQ  one-hot or zero grant, combinational in the request cycle.
REQ-010 rsp_valid  output  NUM_REQ  one-hot or zero; bit i marks rsp_data valid for requester i.
REQ-011 rsp_data  output  12 x D_BITS signed  shared response bus, one triangle record.
REQ-012 mem_addr  output  M_BITS  address to synchronous triangle memory.
REQ-013 mem_en  output  1  memory read enable.
REQ-014 mem_data  input  12 x D_BITS signed  memory read data, valid one cycle after mem_en.

Function
REQ-015 The block SHALL assert at most one gnt bit per cycle, and only for a requester with req high.
REQ-016 With no req bit high, gnt SHALL be 0, mem_en 0, and mem_addr SHALL hold its previous value.
REQ-017 With any req high, gnt SHALL select the first requester with req high at or after rr_ptr, searching upward modulo NUM_REQ.
REQ-018 In a grant cycle, mem_addr SHALL equal the granted requester's req_addr slice and mem_en SHALL be 1, combinationally.
REQ-019 Read latency SHALL be exactly 1 cycle: grant to requester i in cycle N gives rsp_valid = one-hot(i) in cycle N+1.
REQ-020 rsp_data SHALL pass mem_data through unregistered; it is don't-care when rsp_valid is 0.
REQ-021 A requester SHALL hold req and req_addr stable until it sees its gnt bit; de-asserting req before grant cancels the request without error.
REQ-022 A requester MAY keep req high after a grant to issue a new read each cycle; each grant yields exactly one rsp_valid pulse.
REQ-023 rr_ptr SHALL be a log2(NUM_REQ)-bit register; after a grant to i ends a burst, rr_ptr SHALL become (i+1) mod NUM_REQ, wrapping NUM_REQ-1 to 0.
REQ-024 Without grants, rr_ptr SHALL hold its value.
REQ-025 rsp_valid SHALL be registered; gnt, mem_en and mem_addr-on-grant SHALL be combinational from req, req_addr and state.

Reset
REQ-026 While reset is high: rr_ptr = 0, rsp_valid = 0, held mem_addr = 0, burst_cnt = 0, lock owner cleared.
REQ-027 A reset asserted between grant and response SHALL drop the pending rsp_valid; no response after reset release.
REQ-028 gnt and mem_en SHALL be 0 during reset regardless of req.

Configuration
REQ-029 Macro ARB_LOCK_EN SHALL enable burst locking; without it, every grant ends a burst, rr_ptr advances after every grant, and MAX_BURST is unused.
REQ-030 With ARB_LOCK_EN: if requester i was granted last cycle, req[i] is still high, and burst_cnt < MAX_BURST, i SHALL be granted again regardless of rr_ptr.
REQ-031 With ARB_LOCK_EN: burst_cnt SHALL increment per consecutive grant to the same requester; on reaching MAX_BURST or when req[i] drops, the burst ends, rr_ptr becomes i+1 and burst_cnt clears.

Verification
REQ-032 Reset, then req=4'b0001 with addr0=0x010 for 1 cycle -> gnt=0001, mem_addr=0x010, mem_en=1; next cycle rsp_valid=0001 with rsp_data equal to memory[0x010].
REQ-033 No lock, req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; rsp_valid is the same sequence delayed 1 cycle.
REQ-034 No lock, rr_ptr=3, req=4'b1001 -> gnt=1000, then gnt=0001 next cycle (wrap-around).
REQ-035 ARB_LOCK_EN with MAX_BURST=4, req=4'b0011 held -> gnt=0001 for 4 cycles, then 0010 for 4 cycles, then 0001 again.
REQ-036 Grant in cycle N, reset pulsed in cycle N+1 -> rsp_valid=0 in N+1 and after; rr_ptr=0 after reset release.
REQ-037 req=0 for 5 cycles after a read to 0x2A5 -> mem_en=0, gnt=0, mem_addr stays 0x2A5, rsp_valid=0 from the second idle cycle onward.

Source files
------------

// File: rtl/tri_mem_arbiter.sv
// tri_mem_arbiter: round-robin arbiter sharing one synchronous triangle-memory read port among NUM_REQ streamers.
// Latency: gnt/mem_en/mem_addr combinational in the request cycle; rsp_valid registered one cycle later, rsp_data passes mem_data through.
// Backpressure: losers simply wait holding req/req_addr; define ARB_LOCK_EN to let a winner keep the port for up to MAX_BURST reads.
module tri_mem_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned M_BITS    = 12,
    parameter int unsigned D_BITS    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*M_BITS-1:0]  req_addr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic signed [12*D_BITS-1:0] rsp_data,
    output logic [M_BITS-1:0]          mem_addr,
    output logic                       mem_en,
    input  logic signed [12*D_BITS-1:0] mem_data
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
`ifdef ARB_LOCK_EN
    // A winner may keep the port for MAX_BURST consecutive grants.
    localparam int unsigned BURST_LIM = MAX_BURST;
`else
    // Every grant is a complete burst, so the pointer moves after each one.
    localparam int unsigned BURST_LIM = 1;
`endif

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic               owner_vld_q, owner_vld_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [M_BITS-1:0]  addr_q, addr_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

    logic               lock_hold;
    logic               owner_drop;
    logic               gnt_any;
    logic [PTR_W-1:0]   start_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   cand;
    logic [CNT_W-1:0]   cnt_next;

    // (base + off) mod NUM_REQ; both operands are already below NUM_REQ.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return PTR_W'(sum);
    endfunction

    assign rsp_data  = mem_data;
    assign rsp_valid = rsp_valid_q;

    // Pick this cycle's winner: locked owner first, else first req at/after the search start.
    always_comb begin
        lock_hold  = owner_vld_q && req[owner_q];
        owner_drop = owner_vld_q && !req[owner_q];
        // An owner that let go ends its burst now, so search already starts past it.
        start_ptr  = owner_drop ? ptr_add(owner_q, 1) : rr_ptr_q;
        gnt_any    = 1'b0;
        gnt_idx    = '0;
        cand       = '0;
        if (!reset) begin
            if (lock_hold) begin
                gnt_any = 1'b1;
                gnt_idx = owner_q;
            end else begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    cand = ptr_add(start_ptr, k);
                    if (!gnt_any && req[cand]) begin
                        gnt_any = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
        end
        gnt = '0;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
        mem_en   = gnt_any;
        mem_addr = gnt_any ? req_addr[32'(gnt_idx)*M_BITS +: M_BITS] : addr_q;
    end

    // Next-state for pointer, burst tracking, held address and response valid.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        burst_cnt_d = burst_cnt_q;
        addr_d      = addr_q;
        rsp_valid_d = gnt;
        cnt_next    = (lock_hold ? burst_cnt_q : '0) + CNT_W'(1);
        if (owner_drop) begin
            rr_ptr_d    = ptr_add(owner_q, 1);
            owner_vld_d = 1'b0;
            burst_cnt_d = '0;
        end
        if (gnt_any) begin
            addr_d = mem_addr;
            if (cnt_next >= CNT_W'(BURST_LIM)) begin
                rr_ptr_d    = ptr_add(gnt_idx, 1);
                owner_vld_d = 1'b0;
                burst_cnt_d = '0;
            end else begin
                owner_d     = gnt_idx;
                owner_vld_d = 1'b1;
                burst_cnt_d = cnt_next;
            end
        end
    end

    // State registers; reset also drops any response still in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            burst_cnt_q <= '0;
            addr_q      <= '0;
            rsp_valid_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            burst_cnt_q <= burst_cnt_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_tri_mem_arbiter.sv
// tb_tri_mem_arbiter: directed and random stimulus against a behavioural round-robin model.
// Latency: expects combinational grant, one-cycle registered response.
// Backpressure: requesters hold req/addr until granted, may cancel or re-request.
module tb_tri_mem_arbiter;

    localparam int N    = 4;
    localparam int MB   = 12;
    localparam int DB   = 32;
    localparam int MAXB = 4;

    logic                    clock;
    logic                    reset;
    logic [N-1:0]            req;
    logic [N*MB-1:0]         req_addr;
    logic [N-1:0]            gnt;
    logic [N-1:0]            rsp_valid;
    logic signed [12*DB-1:0] rsp_data;
    logic [MB-1:0]           mem_addr;
    logic                    mem_en;
    logic signed [12*DB-1:0] mem_data;

    tri_mem_arbiter #(
        .NUM_REQ  (N),
        .M_BITS   (MB),
        .D_BITS   (DB),
        .MAX_BURST(MAXB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .mem_addr (mem_addr),
        .mem_en   (mem_en),
        .mem_data (mem_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_ptr;
    logic [MB-1:0] m_hold;
    int            m_prev;
    logic [MB-1:0] m_prev_addr;
    int            m_owner;
    int            m_cnt;

    // Last observed values, for directed constant checks
    logic [N-1:0]            obs_gnt;
    logic [N-1:0]            obs_rsp;
    logic [MB-1:0]           obs_addr;
    logic                    obs_en;
    logic [12*DB-1:0]        obs_data;
    logic [N-1:0]            exp_gnt;

    logic [3:0] seq33 [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Triangle memory contents as a fixed function of the address.
    function automatic logic [12*DB-1:0] mem_rec(input logic [MB-1:0] a);
        logic [12*DB-1:0] r;
        for (int j = 0; j < 12; j++) begin
            r[j*DB +: DB] = DB'(32'(a) * 1021 + j * 77 - 3000);
        end
        return r;
    endfunction

    // Synchronous read memory
    always @(posedge clock) begin
        if (mem_en) mem_data <= mem_rec(mem_addr);
    end

    task automatic check_val(input string tag, input logic [12*DB-1:0] got, input logic [12*DB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_ptr = 0; m_hold = '0; m_prev = -1; m_prev_addr = '0; m_owner = -1; m_cnt = 0;
    endfunction

    function automatic int model_pick(input logic [N-1:0] r);
        int start;
        start = m_ptr;
`ifdef ARB_LOCK_EN
        if (m_owner >= 0) begin
            if (r[m_owner]) return m_owner;
            start = (m_owner + 1) % N;
        end
`endif
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_update(input logic [N-1:0] r, input int g, input logic [MB-1:0] ga);
`ifdef ARB_LOCK_EN
        bit hold;
        hold = (m_owner >= 0) && r[m_owner];
        if (m_owner >= 0 && !hold) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0;
        end
        if (g >= 0) begin
            m_cnt = hold ? m_cnt + 1 : 1;
            if (m_cnt >= MAXB) begin
                m_ptr = (g + 1) % N; m_owner = -1; m_cnt = 0;
            end else begin
                m_owner = g;
            end
        end
`else
        if (g >= 0) m_ptr = (g + 1) % N;
`endif
        if (g >= 0) m_hold = ga;
        m_prev      = g;
        m_prev_addr = ga;
    endfunction

    // One clock cycle: drive at posedge+1, check at negedge, advance model.
    task automatic step(input logic [N-1:0] r, input logic [N*MB-1:0] a);
        int            g;
        logic [N-1:0]  eg;
        logic [N-1:0]  er;
        logic [MB-1:0] ea;
        req      = r;
        req_addr = a;
        @(negedge clock);
        g  = model_pick(r);
        eg = '0;
        ea = m_hold;
        if (g >= 0) begin
            eg[g] = 1'b1;
            ea    = a[g*MB +: MB];
        end
        er = '0;
        if (m_prev >= 0) er[m_prev] = 1'b1;
        check_val("gnt", gnt, eg);
        check_val("mem_en", mem_en, (g >= 0));
        check_val("mem_addr", mem_addr, ea);
        check_val("rsp_valid", rsp_valid, er);
        if (m_prev >= 0) check_val("rsp_data", rsp_data, mem_rec(m_prev_addr));
        obs_gnt  = gnt;
        obs_rsp  = rsp_valid;
        obs_addr = mem_addr;
        obs_en   = mem_en;
        obs_data = rsp_data;
        model_update(r, g, ea);
        exp_gnt = eg;
        @(posedge clock);
        #1;
    endtask

    // Reset with all requests high; outputs must stay quiet.
    task automatic do_reset();
        reset = 1'b1;
        req   = '1;
        @(negedge clock);
        check_val("rst_gnt", gnt, '0);
        check_val("rst_mem_en", mem_en, 1'b0);
        check_val("rst_rsp_valid", rsp_valid, '0);
        check_val("rst_mem_addr", mem_addr, '0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        exp_gnt = '0;
    endtask

    initial begin
        logic [N-1:0]    r_cur;
        logic [N*MB-1:0] a_cur;
        reset    = 1'b0;
        req      = '0;
        req_addr = '0;
        mem_data = '0;
        model_reset();
        exp_gnt  = '0;
        #2;
        do_reset();

        // Single read from requester 0
        step(4'b0001, {12'h0, 12'h0, 12'h0, 12'h010});
        check_val("r032_gnt", obs_gnt, 4'b0001);
        check_val("r032_addr", obs_addr, 12'h010);
        check_val("r032_en", obs_en, 1'b1);
        step(4'b0000, '0);
        check_val("r032_rsp", obs_rsp, 4'b0001);
        check_val("r032_data", obs_data, mem_rec(12'h010));

        // All requesting: rotation and delayed responses
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, {12'h333, 12'h222, 12'h111, 12'h000});
`ifndef ARB_LOCK_EN
            check_val("r033_gnt", obs_gnt, seq33[k]);
            if (k > 0) check_val("r033_rsp", obs_rsp, seq33[k-1]);
`endif
        end

        // Wrap-around from pointer 3
        do_reset();
        step(4'b0100, {12'h0, 12'h0AB, 12'h0, 12'h0});
        step(4'b1001, {12'h3C3, 12'h0, 12'h0, 12'h0F0});
`ifndef ARB_LOCK_EN
        check_val("r034_gnt_a", obs_gnt, 4'b1000);
`endif
        step(4'b1001, {12'h3C3, 12'h0, 12'h0, 12'h0F0});
`ifndef ARB_LOCK_EN
        check_val("r034_gnt_b", obs_gnt, 4'b0001);
`endif

`ifdef ARB_LOCK_EN
        // Burst locking with two requesters
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step(4'b0011, {12'h0, 12'h0, 12'h055, 12'h044});
            check_val("r035_gnt", obs_gnt, (k < 4) ? 4'b0001 : ((k < 8) ? 4'b0010 : 4'b0001));
        end
`endif

        // Reset between grant and response
        do_reset();
        step(4'b0010, {12'h0, 12'h0, 12'h123, 12'h0});
        do_reset();
        step(4'b1111, {12'h444, 12'h333, 12'h222, 12'h111});
        check_val("r036_rsp", obs_rsp, 4'b0000);
        check_val("r036_gnt", obs_gnt, 4'b0001);

        // Idle after a read: address held, one trailing response
        step(4'b0100, {12'h0, 12'h2A5, 12'h0, 12'h0});
        for (int k = 0; k < 5; k++) begin
            step(4'b0000, {12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF});
            check_val("r037_en", obs_en, 1'b0);
            check_val("r037_gnt", obs_gnt, 4'b0000);
            check_val("r037_addr", obs_addr, 12'h2A5);
            check_val("r037_rsp", obs_rsp, (k == 0) ? 4'b0100 : 4'b0000);
        end

        // Random traffic: hold until granted, occasional cancel, occasional reset
        r_cur = '0;
        a_cur = '0;
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                do_reset();
                r_cur = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (r_cur[i] && !exp_gnt[i]) begin
                    if ($urandom_range(0, 15) == 0) r_cur[i] = 1'b0;
                end else begin
                    r_cur[i] = ($urandom_range(0, 2) != 0);
                    a_cur[i*MB +: MB] = MB'($urandom_range(0, 4095));
                end
            end
            step(r_cur, a_cur);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
